// File: rtl/core_pkg.sv
// Shared core types: data width, response FSM states, store-buffer entry
// and the byte-lane merge used by store-to-load forwarding.
package core_pkg;
  localparam int XLEN   = 32;
  localparam int MASK_W = 4;
  localparam int IDX_W  = XLEN - 2;

  typedef enum logic {RSP_IDLE, RSP_HOLD} rsp_state_e;

  typedef struct packed {
    logic              valid;
    logic [IDX_W-1:0]  idx;
    logic [XLEN-1:0]   data;
    logic [MASK_W-1:0] mask;
  } sbuf_t;

  function automatic logic [XLEN-1:0] byte_merge(input logic [XLEN-1:0]   base,
                                                 input logic [XLEN-1:0]   over,
                                                 input logic [MASK_W-1:0] mask);
    logic [XLEN-1:0] r;
    r = base;
    for (int k = 0; k < MASK_W; k++)
      if (mask[k]) r[8*k +: 8] = over[8*k +: 8];
    return r;
  endfunction
endpackage

// File: rtl/dmem_resp_if.sv
// Load/store request and held response channel between execute unit and data memory.
interface dmem_resp_if;
  logic        req_valid_i;
  logic        req_ready_o;
  logic        req_wen_i;
  logic [31:0] req_addr_i;
  logic [31:0] req_wdata_i;
  logic [3:0]  req_wmask_i;
  logic        rsp_valid_o;
  logic        rsp_ready_i;
  logic [31:0] rsp_rdata_o;
  logic        rsp_err_o;

  modport master (output req_valid_i, req_wen_i, req_addr_i, req_wdata_i, req_wmask_i, rsp_ready_i,
                  input  req_ready_o, rsp_valid_o, rsp_rdata_o, rsp_err_o);
  modport slave  (input  req_valid_i, req_wen_i, req_addr_i, req_wdata_i, req_wmask_i, rsp_ready_i,
                  output req_ready_o, rsp_valid_o, rsp_rdata_o, rsp_err_o);
endinterface

// File: rtl/dmem_sram.sv
// Single-port word RAM with byte enables and one-cycle registered read.
module dmem_sram #(
  parameter int DEPTH_WORDS = 4096,
  parameter int AW          = $clog2(DEPTH_WORDS)
) (
  input  logic          clk,
  input  logic          en,
  input  logic          we,
  input  logic [3:0]    be,
  input  logic [AW-1:0] addr,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);
  logic [31:0] mem [DEPTH_WORDS];

  // Read data only moves on a read, so a stalled load response stays stable across drains.
  always_ff @(posedge clk) begin
    if (en && we) begin
      for (int k = 0; k < 4; k++)
        if (be[k]) mem[addr][8*k +: 8] <= wdata[8*k +: 8];
    end
    if (en && !we) rdata <= mem[addr];
  end
endmodule

// File: rtl/dmem_resp.sv
// Data-memory responder: posted one-entry store buffer, 1-cycle loads with
// store-to-load forwarding, and a held backpressurable response register.
module dmem_resp
  import core_pkg::*;
#(
  parameter int DEPTH_WORDS = 4096,
  localparam int AW = $clog2(DEPTH_WORDS)
) (
  input logic         clk,
  input logic         rst,
  dmem_resp_if.slave  bus
);
  rsp_state_e        state;
  sbuf_t             sb;
  logic              rsp_load;
  logic              rsp_err;
  logic [XLEN-1:0]   fwd_data;
  logic [MASK_W-1:0] fwd_mask;
  logic [XLEN-1:0]   ram_q;

  logic [AW-1:0] idx;
  logic          in_range, accept, ld_acc, st_acc, drain, hit;

  assign idx      = bus.req_addr_i[AW+1:2];
  assign in_range = (bus.req_addr_i >> (AW + 2)) == '0;
  assign accept   = bus.req_valid_i && bus.req_ready_o;
  assign ld_acc   = accept && !bus.req_wen_i && in_range;
  assign st_acc   = accept &&  bus.req_wen_i && in_range;
  // An accepted load owns the single RAM port; otherwise a buffered store drains.
  assign drain    = sb.valid && !ld_acc && !rst;
  assign hit      = sb.valid && (sb.idx == IDX_W'(idx));

  dmem_sram #(.DEPTH_WORDS(DEPTH_WORDS), .AW(AW)) u_sram (
    .clk   (clk),
    .en    (!rst && (ld_acc || drain)),
    .we    (drain),
    .be    (sb.mask),
    .addr  (drain ? sb.idx[AW-1:0] : idx),
    .wdata (sb.data),
    .rdata (ram_q)
  );

  assign bus.req_ready_o = (state == RSP_IDLE) || bus.rsp_ready_i;
  assign bus.rsp_valid_o = (state == RSP_HOLD);
  assign bus.rsp_err_o   = rsp_err;
  assign bus.rsp_rdata_o = rsp_load ? byte_merge(ram_q, fwd_data, fwd_mask) : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= RSP_IDLE;
      sb       <= '0;
      rsp_load <= 1'b0;
      rsp_err  <= 1'b0;
      fwd_data <= '0;
      fwd_mask <= '0;
    end else begin
      if (st_acc) begin
        sb.valid <= 1'b1;
        sb.idx   <= IDX_W'(idx);
        sb.data  <= bus.req_wdata_i;
        sb.mask  <= bus.req_wmask_i;
      end else if (drain) begin
        sb.valid <= 1'b0;
      end

      if (accept) begin
        state    <= RSP_HOLD;
        rsp_err  <= !in_range;
        rsp_load <= ld_acc;
        fwd_mask <= hit ? sb.mask : '0;
        fwd_data <= sb.data;
      end else if (bus.rsp_ready_i) begin
        state    <= RSP_IDLE;
        rsp_load <= 1'b0;
        rsp_err  <= 1'b0;
      end
    end
  end
endmodule

// File: doc/dmem_resp.md
# dmem_resp

Data-memory responder for the single-issue core: the memory-side end of the execute unit's load/store interface (address, lane-positioned write data, byte write mask, write enable, read data). It owns a single-port, word-organised data RAM with byte enables. It posts stores into a one-entry store buffer, serves loads with one-cycle latency and store-to-load forwarding, and returns every request as a held, backpressurable response.

## Interface
- `DEPTH_WORDS`, default 4096: RAM depth in 32-bit words; power of two. `AW = $clog2(DEPTH_WORDS)`.
- `clk` in 1: the only clock.
- `rst` in 1: reset, synchronous, active-high.
- `req_valid_i` in 1: request present.
- `req_ready_o` out 1: request accepted when `req_valid_i && req_ready_o` at a rising edge.
- `req_wen_i` in 1: 1 = store, 0 = load.
- `req_addr_i` in 32: byte address; bits [1:0] ignored.
- `req_wdata_i` in 32: store data, already placed in its byte lanes.
- `req_wmask_i` in 4: store byte enables; bit k enables byte lane [8k+7:8k].
- `rsp_valid_o` out 1: response held valid until consumed.
- `rsp_ready_i` in 1: consumer takes the response.
- `rsp_rdata_o` out 32: full load word (lane extraction and sign extension belong to the requester); 0 for stores.
- `rsp_err_o` out 1: address out of range.

## Operation
- Word index: `idx = req_addr_i[AW+1:2]`.
- Out of range: `req_addr_i[31:AW+2] != 0`.
  - The request is still accepted and answered with `rsp_err_o = 1` and `rsp_rdata_o = 0`.
  - An out-of-range store never enters the buffer.
  - An out-of-range load performs no RAM read.
- Store buffer holds one entry: `buf_valid`, `buf_idx`, `buf_data`, `buf_mask`.
- Drain: in every cycle where `buf_valid` is set and no in-range load is accepted, the entry is written to RAM under `buf_mask`.
- Accepted in-range store:
  - The new store is loaded into the buffer at the same edge the old entry drains.
  - A store is therefore always accepted regardless of buffer state.
  - Stores to the same word are not merged.
- Accepted in-range load:
  - RAM word `idx` is read. The buffer does not drain that cycle.
  - If `buf_valid && buf_idx == idx`, each byte whose `buf_mask` bit is set is replaced by the `buf_data` byte.
  - The forward mask and data are captured at the accept edge.
- Response register FSM:
  - IDLE (`rsp_valid_o = 0`) → HOLD on accept.
  - HOLD → IDLE on `rsp_ready_i` with no new accept.
  - HOLD → HOLD on `rsp_ready_i` with a new accept (back-to-back).
  - HOLD with `!rsp_ready_i`: outputs stay frozen.
- `req_ready_o = !rsp_valid_o || rsp_ready_i`; purely combinational, with no dependency on `req_valid_i`.
- RAM contents are not reset and are undefined until written.

## Timing
- Load and store latency: accept at edge N, response valid from edge N until it is consumed (first visible in the cycle after edge N).
- Throughput is one request per cycle while `rsp_ready_i = 1`.
- A store accepted at edge N is forwarded to a load accepted at edge N+1 or later while still buffered. After draining, the store is visible from the RAM.
- While the response is stalled, the buffer still drains in idle cycles.
- Reset values: `rsp_valid_o = 0`, `rsp_rdata_o = 0`, `rsp_err_o = 0`, `buf_valid = 0`, state IDLE. `req_ready_o` is therefore 1 during and after reset.
- Reset mid-operation:
  - A buffered, undrained store is discarded.
  - A pending response is dropped.
  - No RAM write occurs in a cycle with `rst = 1`.

## Structure
- Shared package `core_pkg` holds:
  - `XLEN = 32` and `MASK_W = 4`;
  - the response state enum (`RSP_IDLE`, `RSP_HOLD`);
  - the store-buffer entry struct (`valid`, `idx`, `data`, `mask`).
- Sub-module `dmem_sram`: single-port synchronous RAM with `clk`, `en`, `we`, `be[3:0]`, `addr[AW-1:0]`, `wdata`, `rdata`, one-cycle read latency. No reset.
- `dmem_resp` contains the arbitration, the store buffer, the forwarding merge and the response FSM.

## Test plan
- Store then load, same word:
  - Stimulus: store addr 0x10, data 0xAABBCCDD, mask 4'b1111; then immediately load 0x10 with `rsp_ready_i = 1`.
  - Required: store response has rdata 0, err 0; load response rdata 0xAABBCCDD via forwarding.
- Partial store over drained data:
  - Stimulus: with word 0x20 = 0x11223344 already drained, store data 0x0000EE00, mask 4'b0010; then load 0x20.
  - Required: rdata 0x1122EE44, both forwarded and after one idle drain cycle.
- Out of range:
  - Stimulus: `DEPTH_WORDS = 4096`, store then load to 0x0000_4000.
  - Required: both responses have `rsp_err_o = 1`, rdata 0; word 0 is unchanged.
- Backpressure:
  - Stimulus: hold `rsp_ready_i = 0` for 3 cycles after a load of 0x10.
  - Required: `req_ready_o = 0` and response frozen through the hold; the next request is accepted in the cycle `rsp_ready_i` rises.
- Back-to-back stores with a load between:
  - Stimulus: stores to 0x30 (0x1) and 0x34 (0x2), then load 0x30.
  - Required: load returns 0x1 from RAM; a later load of 0x34 returns 0x2.
- Reset mid-operation:
  - Stimulus: store 0x40 = 0xDEADBEEF, assert `rst` the next cycle before any idle cycle, then load 0x40.
  - Required: all outputs return to reset values; the load returns the pre-store RAM content, not 0xDEADBEEF.
